// File: rtl/ram_sp_arbiter.sv
// Two-client round-robin arbiter/sequencer for a single-port synchronous RAM.
// Optional post-reset zero-fill of the whole RAM: define RAM_ARB_INIT_CLEAR_EN.
module ram_sp_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ack,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ack,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    if (RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_chk
        $error("RAM_DEPTH exceeds the address space");
    end

    logic                  r_last_grant;
    logic                  r_init_done;
    logic                  r_p1_vld, r_p1_rd, r_p1_id;
    logic                  r_p2_vld, r_p2_rd, r_p2_id;
    logic                  w_arb;
    logic                  w_elig0, w_elig1;
    logic                  w_gnt0, w_gnt1, w_gnt;
    logic                  w_cmd_we;
    logic [ADDR_WIDTH-1:0] w_cmd_addr;
    logic [DATA_WIDTH-1:0] w_cmd_wdata;

`ifdef RAM_ARB_INIT_CLEAR_EN
    typedef enum logic {ST_INIT, ST_ARB} state_t;
    localparam logic [ADDR_WIDTH:0] LP_LAST = (ADDR_WIDTH+1)'(RAM_DEPTH - 1);
    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_init_cnt;
    assign w_arb = (r_state == ST_ARB);
`else
    assign w_arb = 1'b1;
`endif

    // A request still showing its ack was just issued; masking it prevents a double issue.
    assign w_elig0     = req0_valid & ~req0_ack & w_arb;
    assign w_elig1     = req1_valid & ~req1_ack & w_arb;
    assign w_gnt0      = w_elig0 & (~w_elig1 | r_last_grant);
    assign w_gnt1      = w_elig1 & ~w_gnt0;
    assign w_gnt       = w_gnt0 | w_gnt1;
    assign w_cmd_we    = w_gnt1 ? req1_we    : req0_we;
    assign w_cmd_addr  = w_gnt1 ? req1_addr  : req0_addr;
    assign w_cmd_wdata = w_gnt1 ? req1_wdata : req0_wdata;

    assign init_done  = r_init_done;
    assign rsp0_valid = r_p2_vld & r_p2_rd & ~r_p2_id;
    assign rsp1_valid = r_p2_vld & r_p2_rd &  r_p2_id;
    assign rsp0_rdata = ram_rdata;
    assign rsp1_rdata = ram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_cs       <= 1'b0;
            ram_we       <= 1'b0;
            ram_oe       <= 1'b0;
            ram_address  <= '0;
            ram_wdata    <= '0;
            req0_ack     <= 1'b0;
            req1_ack     <= 1'b0;
            r_last_grant <= 1'b1;
            r_p1_vld     <= 1'b0;
            r_p1_rd      <= 1'b0;
            r_p1_id      <= 1'b0;
            r_p2_vld     <= 1'b0;
            r_p2_rd      <= 1'b0;
            r_p2_id      <= 1'b0;
`ifdef RAM_ARB_INIT_CLEAR_EN
            r_state      <= ST_INIT;
            r_init_cnt   <= '0;
            r_init_done  <= 1'b0;
`else
            r_init_done  <= 1'b1;
`endif
        end else begin
            req0_ack <= w_gnt0;
            req1_ack <= w_gnt1;
            // Response tracker: stage 1 matches the RAM command, stage 2 the returned data.
            r_p1_vld <= w_gnt;
            r_p1_rd  <= ~w_cmd_we;
            r_p1_id  <= w_gnt1;
            r_p2_vld <= r_p1_vld;
            r_p2_rd  <= r_p1_rd;
            r_p2_id  <= r_p1_id;
            if (w_gnt) begin
                ram_cs       <= 1'b1;
                ram_we       <= w_cmd_we;
                ram_oe       <= ~w_cmd_we;
                ram_address  <= w_cmd_addr;
                ram_wdata    <= w_cmd_wdata;
                r_last_grant <= w_gnt1;
            end else begin
                ram_cs <= 1'b0;
                ram_we <= 1'b0;
                ram_oe <= 1'b0;
            end
`ifdef RAM_ARB_INIT_CLEAR_EN
            if (r_state == ST_INIT) begin
                ram_cs      <= 1'b1;
                ram_we      <= 1'b1;
                ram_oe      <= 1'b0;
                ram_address <= r_init_cnt[ADDR_WIDTH-1:0];
                ram_wdata   <= '0;
                r_init_cnt  <= r_init_cnt + 1'b1;
                if (r_init_cnt == LP_LAST) begin
                    r_state     <= ST_ARB;
                    r_init_done <= 1'b1;
                end
            end
`endif
        end
    end

endmodule
